ad9959_multi_master: RTL and testbench

- Parametrised successor of the two-channel AD9958 master, for the AD9958/AD9959 family with 1–4 channels.
- Holds an internal SPI serialiser and runs the DDS power-up sequence: master reset, then CSR and FR1 config writes.
- Then watches the per-channel frequency tuning word (FTW) and amplitude scale factor (ASF) inputs. It writes only channels whose value changed since the last commit, then pulses io_update once per batch.
- Sits between the application's tuning registers and the DDS pins.

---
 rtl/ad9959_multi_master.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_ad9959_multi_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9959_multi_master.sv
// AD9958/AD9959 master: power-up sequencing, then change-driven per-channel FTW/ASF writes with io_update commits.
// Optional macro QUAD_SDIO_EN: frames after the initial CSR write shift a nibble per SCLK on sdio[3:0].
module ad9959_multi_master #(
  parameter int         NUM_CH     = 2,
  parameter int         CLK_DIV    = 2,
  parameter int         MR_CYCLES  = 16,
  parameter int         IOU_CYCLES = 4,
  parameter logic [4:0] PLL_MULT   = 5'd20,
  parameter logic       VCO_GAIN   = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [32*NUM_CH-1:0] ftw,
  input  logic [10*NUM_CH-1:0] asf,
  output logic                 cs,
  output logic                 sclk,
  output logic [3:0]           sdio,
  output logic                 master_reset,
  output logic                 io_update,
  output logic                 busy,
  output logic [15:0]          commit_count
);

  localparam logic [3:0] ST_MR       = 4'd0;
  localparam logic [3:0] ST_INIT_CSR = 4'd1;
  localparam logic [3:0] ST_INIT_FR1 = 4'd2;
  localparam logic [3:0] ST_IDLE     = 4'd3;
  localparam logic [3:0] ST_SCAN     = 4'd4;
  localparam logic [3:0] ST_CH_CSR   = 4'd5;
  localparam logic [3:0] ST_CH_FTW   = 4'd6;
  localparam logic [3:0] ST_CH_ACR   = 4'd7;
  localparam logic [3:0] ST_NEXT     = 4'd8;
  localparam logic [3:0] ST_UPDATE   = 4'd9;

  localparam logic [2:0] SP_IDLE  = 3'd0;
  localparam logic [2:0] SP_SETUP = 3'd1;
  localparam logic [2:0] SP_HIGH  = 3'd2;
  localparam logic [2:0] SP_LOW   = 3'd3;
  localparam logic [2:0] SP_HOLD  = 3'd4;
  localparam logic [2:0] SP_GAP   = 3'd5;

  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [15:0] MR_LEN  = 16'(MR_CYCLES);
  localparam logic [15:0] MR_END  = 16'(MR_CYCLES + 4);
  localparam logic [15:0] IOU_LEN = 16'(IOU_CYCLES);

`ifdef QUAD_SDIO_EN
  localparam logic       QUAD_MODE   = 1'b1;
  localparam logic [7:0] CSR_INIT    = 8'hF6;
  localparam logic [3:0] CSR_CH_MODE = 4'b0110;
`else
  localparam logic       QUAD_MODE   = 1'b0;
  localparam logic [7:0] CSR_INIT    = 8'hF0;
  localparam logic [3:0] CSR_CH_MODE = 4'b0000;
`endif

  logic [2:0]  sp_state_q, sp_state_d;
  logic [15:0] div_q, div_d;
  logic        cs_q, cs_d, sclk_q, sclk_d, quad_q, quad_d;
  logic [39:0] sh_q, sh_d;
  logic [5:0]  left_q, left_d;
  logic        sp_done, spi_start;

  logic [3:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d, commit_q, commit_d;
  logic        sent_q, sent_d, init_q, init_d;
  logic        master_reset_q, master_reset_d, io_update_q, io_update_d;
  logic [1:0]  ch_q, ch_d;
  logic [NUM_CH-1:0]   dirty_q, dirty_d, dirty_now;
  logic [32*NUM_CH-1:0] snap_ftw_q, snap_ftw_d, shadow_ftw_q, shadow_ftw_d;
  logic [10*NUM_CH-1:0] snap_asf_q, snap_asf_d, shadow_asf_q, shadow_asf_d;

  logic [39:0] frame_word;
  logic [2:0]  frame_bytes;
  logic        frame_quad;
  logic [5:0]  frame_cycles;
  logic [3:0]  frame_next;
  logic [31:0] ftw_sel;
  logic [9:0]  asf_sel;
  logic [3:0]  ch_onehot;

  assign cs           = cs_q;
  assign sclk         = sclk_q;
  assign master_reset = master_reset_q;
  assign io_update    = io_update_q;
  assign busy         = (state_q != ST_IDLE);
  assign commit_count = commit_q;

`ifdef QUAD_SDIO_EN
  assign sdio = quad_q ? sh_q[39:36] : {3'b000, sh_q[39]};
`else
  assign sdio = {3'b000, sh_q[39]};
`endif

  // Serialiser: data is loaded with cs falling and advances on each SCLK fall.
  always_comb begin
    sp_state_d = sp_state_q;
    div_d      = div_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    sh_d       = sh_q;
    left_d     = left_q;
    quad_d     = quad_q;
    sp_done    = 1'b0;
    if (sp_state_q == SP_IDLE) begin
      if (spi_start) begin
        sh_d       = frame_word;
        left_d     = frame_cycles;
        quad_d     = frame_quad;
        cs_d       = 1'b0;
        div_d      = DIV_MAX;
        sp_state_d = SP_SETUP;
      end
    end else if (div_q != 16'd0) begin
      div_d = div_q - 16'd1;
    end else begin
      div_d = DIV_MAX;
      case (sp_state_q)
        SP_SETUP, SP_LOW: begin
          sclk_d     = 1'b1;
          sp_state_d = SP_HIGH;
        end
        SP_HIGH: begin
          sclk_d     = 1'b0;
          sh_d       = quad_q ? {sh_q[35:0], 4'h0} : {sh_q[38:0], 1'b0};
          left_d     = left_q - 6'd1;
          sp_state_d = (left_q == 6'd1) ? SP_HOLD : SP_LOW;
        end
        SP_HOLD: begin
          cs_d       = 1'b1;
          sp_state_d = SP_GAP;
        end
        SP_GAP: begin
          sp_state_d = SP_IDLE;
          sp_done    = 1'b1;
        end
        default: sp_state_d = SP_IDLE;
      endcase
    end
  end

  always_comb begin
    ftw_sel = '0;
    asf_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == 2'(k)) begin
        ftw_sel = snap_ftw_q[32*k +: 32];
        asf_sel = snap_asf_q[10*k +: 10];
      end
    end
    ch_onehot   = 4'b0001 << ch_q;
    frame_word  = '0;
    frame_bytes = 3'd2;
    frame_quad  = QUAD_MODE;
    frame_next  = state_q;
    case (state_q)
      ST_INIT_CSR: begin
        frame_word = {8'h00, CSR_INIT, 24'h0};
        frame_quad = 1'b0;
        frame_next = ST_INIT_FR1;
      end
      ST_INIT_FR1: begin
        frame_word  = {8'h01, VCO_GAIN, PLL_MULT, 2'b00, 16'h0000, 8'h00};
        frame_bytes = 3'd4;
        frame_next  = ST_IDLE;
      end
      ST_CH_CSR: begin
        frame_word = {8'h00, ch_onehot, CSR_CH_MODE, 24'h0};
        frame_next = ST_CH_FTW;
      end
      ST_CH_FTW: begin
        frame_word  = {8'h04, ftw_sel};
        frame_bytes = 3'd5;
        frame_next  = ST_CH_ACR;
      end
      ST_CH_ACR: begin
        frame_word  = {8'h06, 11'h000, 1'b1, 2'b00, asf_sel, 8'h00};
        frame_bytes = 3'd4;
        frame_next  = ST_NEXT;
      end
      default: ;
    endcase
    frame_cycles = frame_quad ? {2'b00, frame_bytes, 1'b0} : {frame_bytes, 3'b000};
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      dirty_now[k] = init_q
                   | (ftw[32*k +: 32] != shadow_ftw_q[32*k +: 32])
                   | (asf[10*k +: 10] != shadow_asf_q[10*k +: 10]);
    end
  end

  // Sequencer: every frame state issues one frame, then moves on when the serialiser reports the cs-high gap done.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sent_d         = sent_q;
    init_d         = init_q;
    commit_d       = commit_q;
    master_reset_d = 1'b0;
    io_update_d    = 1'b0;
    ch_d           = ch_q;
    dirty_d        = dirty_q;
    snap_ftw_d     = snap_ftw_q;
    snap_asf_d     = snap_asf_q;
    shadow_ftw_d   = shadow_ftw_q;
    shadow_asf_d   = shadow_asf_q;
    spi_start      = 1'b0;
    case (state_q)
      ST_MR: begin
        cnt_d          = cnt_q + 16'd1;
        master_reset_d = (cnt_q < MR_LEN);
        if (cnt_q == MR_END) begin
          cnt_d   = '0;
          state_d = ST_INIT_CSR;
        end
      end
      ST_INIT_CSR, ST_INIT_FR1, ST_CH_CSR, ST_CH_FTW, ST_CH_ACR: begin
        if (!sent_q && sp_state_q == SP_IDLE) begin
          spi_start = 1'b1;
          sent_d    = 1'b1;
        end else if (sp_done) begin
          sent_d  = 1'b0;
          state_d = frame_next;
          if (state_q == ST_CH_ACR) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (ch_q == 2'(k)) begin
                shadow_ftw_d[32*k +: 32] = snap_ftw_q[32*k +: 32];
                shadow_asf_d[10*k +: 10] = snap_asf_q[10*k +: 10];
                dirty_d[k]               = 1'b0;
              end
            end
          end
        end
      end
      ST_IDLE: begin
        if (|dirty_now) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        snap_ftw_d = ftw;
        snap_asf_d = asf;
        dirty_d    = dirty_now;
        state_d    = (|dirty_now) ? ST_NEXT : ST_IDLE;
      end
      ST_NEXT: begin
        if (|dirty_q) begin
          for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (dirty_q[k]) ch_d = 2'(k);
          end
          state_d = ST_CH_CSR;
        end else begin
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        cnt_d       = cnt_q + 16'd1;
        io_update_d = (cnt_q < IOU_LEN);
        if (cnt_q == IOU_LEN) begin
          cnt_d    = '0;
          commit_d = commit_q + 16'd1;
          init_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_MR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_state_q <= SP_IDLE;
      div_q      <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      sh_q       <= '0;
      left_q     <= '0;
      quad_q     <= 1'b0;
    end else begin
      sp_state_q <= sp_state_d;
      div_q      <= div_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      sh_q       <= sh_d;
      left_q     <= left_d;
      quad_q     <= quad_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_MR;
      cnt_q          <= '0;
      sent_q         <= 1'b0;
      init_q         <= 1'b1;
      commit_q       <= '0;
      master_reset_q <= 1'b0;
      io_update_q    <= 1'b0;
      ch_q           <= '0;
      dirty_q        <= '0;
      snap_ftw_q     <= '0;
      snap_asf_q     <= '0;
      shadow_ftw_q   <= '0;
      shadow_asf_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sent_q         <= sent_d;
      init_q         <= init_d;
      commit_q       <= commit_d;
      master_reset_q <= master_reset_d;
      io_update_q    <= io_update_d;
      ch_q           <= ch_d;
      dirty_q        <= dirty_d;
      snap_ftw_q     <= snap_ftw_d;
      snap_asf_q     <= snap_asf_d;
      shadow_ftw_q   <= shadow_ftw_d;
      shadow_asf_q   <= shadow_asf_d;
    end
  end

endmodule

// File: tb/tb_ad9959_multi_master.sv
// Scoreboard bench for ad9959_multi_master: decodes SPI frames and io_update pulses and compares them
// against a queue of expected events pushed as each stimulus step is applied.
module tb_ad9959_multi_master;

  localparam int         NUM_CH     = 2;
  localparam int         CLK_DIV    = 2;
  localparam int         MR_CYCLES  = 16;
  localparam int         IOU_CYCLES = 4;
  localparam logic [4:0] PLL_MULT   = 5'd20;
  localparam logic       VCO_GAIN   = 1'b1;

`ifdef QUAD_SDIO_EN
  localparam bit         QUAD     = 1'b1;
  localparam logic [7:0] CSR_INIT = 8'hF6;
  localparam logic [3:0] CH_MODE  = 4'h6;
`else
  localparam bit         QUAD     = 1'b0;
  localparam logic [7:0] CSR_INIT = 8'hF0;
  localparam logic [3:0] CH_MODE  = 4'h0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] ftw;
  logic [19:0] asf;
  logic        cs, sclk, master_reset, io_update, busy;
  logic [3:0]  sdio;
  logic [15:0] commit_count;

  always #5 clock = ~clock;

  ad9959_multi_master #(
    .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .MR_CYCLES(MR_CYCLES),
    .IOU_CYCLES(IOU_CYCLES), .PLL_MULT(PLL_MULT), .VCO_GAIN(VCO_GAIN)
  ) dut (
    .clock(clock), .reset(reset), .ftw(ftw), .asf(asf),
    .cs(cs), .sclk(sclk), .sdio(sdio), .master_reset(master_reset),
    .io_update(io_update), .busy(busy), .commit_count(commit_count)
  );

  typedef struct {
    bit          is_iou;
    int          nbytes;
    logic [63:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;

  int          cur_bits = 0, cur_sclks = 0, mr_len = 0, iou_len = 0, frames_after_mr = 0;
  logic [63:0] cur_data = '0;
  bit          quad_active = 1'b0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mr = 1'b0, prev_iou = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushFrame(input int nbytes, input logic [63:0] data);
    ev_t e;
    e.is_iou = 1'b0;
    e.nbytes = nbytes;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic pushIou();
    ev_t e;
    e.is_iou = 1'b1;
    e.nbytes = 0;
    e.data   = '0;
    exp_q.push_back(e);
  endtask

  task automatic pushChannel(input int k, input logic [31:0] f, input logic [9:0] a);
    logic [7:0] csr;
    csr = (8'h10 << k) | {4'h0, CH_MODE};
    pushFrame(2, {48'h0, 8'h00, csr});
    pushFrame(5, {24'h0, 8'h04, f});
    pushFrame(4, {32'h0, 8'h06, 11'h000, 1'b1, 2'b00, a});
  endtask

  task automatic pushPowerUp(input logic [31:0] f0, input logic [9:0] a0,
                             input logic [31:0] f1, input logic [9:0] a1);
    pushFrame(2, {48'h0, 8'h00, CSR_INIT});
    pushFrame(4, {32'h0, 8'h01, VCO_GAIN, PLL_MULT, 2'b00, 16'h0000});
    pushChannel(0, f0, a0);
    pushChannel(1, f1, a1);
    pushIou();
  endtask

  task automatic applyStimulus(input logic [31:0] f0, input logic [9:0] a0,
                               input logic [31:0] f1, input logic [9:0] a1);
    @(posedge clock);
    #1;
    ftw = {f1, f0};
    asf = {a1, a0};
  endtask

  task automatic frameDone();
    ev_t e;
    if (exp_q.size() == 0) begin
      checkOutput("frame_unexpected_bits", 64'(cur_bits), 64'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind_frame", {63'd0, e.is_iou}, 64'd0);
      checkOutput("frame_bits", 64'(cur_bits), 64'(8 * e.nbytes));
      checkOutput("frame_sclks", 64'(cur_sclks), 64'(quad_active ? 2 * e.nbytes : 8 * e.nbytes));
      checkOutput("frame_data", cur_data, e.data);
    end
    if (frames_after_mr == 0) quad_active = QUAD;
    frames_after_mr++;
    cur_bits  = 0;
    cur_sclks = 0;
    cur_data  = '0;
  endtask

  task automatic iouDone();
    ev_t e;
    if (exp_q.size() == 0) begin
      checkOutput("io_update_unexpected_len", 64'(iou_len), 64'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind_iou", {63'd0, e.is_iou}, 64'd1);
      checkOutput("io_update_len", 64'(iou_len), 64'(IOU_CYCLES));
    end
    iou_len = 0;
  endtask

  // Decoder: samples on the falling system clock, away from the edge where DUT outputs change.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        cur_bits        = 0;
        cur_sclks       = 0;
        cur_data        = '0;
        mr_len          = 0;
        iou_len         = 0;
        quad_active     = 1'b0;
        frames_after_mr = 0;
      end else begin
        if (!cs && sclk && !prev_sclk) begin
          if (quad_active) begin
            cur_data = {cur_data[59:0], sdio};
            cur_bits += 4;
          end else begin
            cur_data = {cur_data[62:0], sdio[0]};
            cur_bits += 1;
          end
          cur_sclks++;
        end
        if (cs && !prev_cs) frameDone();
        if (master_reset) begin
          mr_len++;
        end else if (prev_mr) begin
          checkOutput("master_reset_len", 64'(mr_len), 64'(MR_CYCLES));
          mr_len          = 0;
          quad_active     = 1'b0;
          frames_after_mr = 0;
        end
        if (io_update) iou_len++;
        else if (prev_iou) iouDone();
      end
      prev_cs   = cs;
      prev_sclk = sclk;
      prev_mr   = master_reset;
      prev_iou  = io_update;
    end
  end

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while ((busy || exp_q.size() != 0) && n < budget);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    checkOutput({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic waitFrame(input logic [7:0] instr, input int sclks, input int budget, output bit found);
    logic [63:0] t;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clock);
      #1;
      if (!cs && cur_sclks == sclks && cur_bits >= 8) begin
        t = cur_data >> (cur_bits - 8);
        if (t[7:0] == instr) found = 1'b1;
      end
    end
  endtask

  initial begin
    bit found;
    int n;

    reset = 1'b1;
    ftw   = '0;
    asf   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    checkOutput("reset_cs", 64'(cs), 64'd1);
    checkOutput("reset_sclk", 64'(sclk), 64'd0);
    checkOutput("reset_sdio", 64'(sdio), 64'd0);
    checkOutput("reset_io_update", 64'(io_update), 64'd0);
    checkOutput("reset_master_reset", 64'(master_reset), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd1);
    checkOutput("reset_commit", 64'(commit_count), 64'd0);

    $display("[TB] power-up sequence");
    pushPowerUp(32'h0, 10'h0, 32'h0, 10'h0);
    reset = 1'b0;
    waitIdle("powerup", 5000);
    checkOutput("powerup_commit", 64'(commit_count), 64'd1);

    $display("[TB] single channel change");
    pushChannel(1, 32'h1999_999A, 10'h000);
    pushIou();
    applyStimulus(32'h0, 10'h000, 32'h1999_999A, 10'h000);
    waitIdle("single", 3000);
    checkOutput("single_commit", 64'(commit_count), 64'd2);

    $display("[TB] both channels in one clock");
    pushChannel(0, 32'h0, 10'h3FF);
    pushChannel(1, 32'h1234_5678, 10'h000);
    pushIou();
    applyStimulus(32'h0, 10'h3FF, 32'h1234_5678, 10'h000);
    waitIdle("both", 4000);
    checkOutput("both_commit", 64'(commit_count), 64'd3);

    $display("[TB] change during transfer");
    pushChannel(1, 32'hCAFE_F00D, 10'h000);
    pushIou();
    applyStimulus(32'h0, 10'h3FF, 32'hCAFE_F00D, 10'h000);
    waitFrame(8'h04, QUAD ? 4 : 16, 3000, found);
    checkOutput("ftw_frame_reached", 64'(found), 64'd1);
    pushChannel(0, 32'h0000_5555, 10'h3FF);
    pushIou();
    applyStimulus(32'h0000_5555, 10'h3FF, 32'hCAFE_F00D, 10'h000);
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (commit_count != 16'd4 && n < 3000);
    checkOutput("first_batch_commit", 64'(commit_count), 64'd4);
    checkOutput("busy_gap_between_batches", 64'(busy), 64'd0);
    waitIdle("second_batch", 3000);
    checkOutput("second_batch_commit", 64'(commit_count), 64'd5);

    $display("[TB] reset mid-frame");
    pushChannel(0, 32'h0BAD_BEEF, 10'h3FF);
    pushIou();
    applyStimulus(32'h0BAD_BEEF, 10'h3FF, 32'hCAFE_F00D, 10'h000);
    waitFrame(8'h04, 10, 3000, found);
    checkOutput("mid_frame_reached", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    checkOutput("midreset_cs", 64'(cs), 64'd1);
    checkOutput("midreset_sclk", 64'(sclk), 64'd0);
    checkOutput("midreset_commit", 64'(commit_count), 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd1);
    exp_q.delete();
    pushPowerUp(32'h0BAD_BEEF, 10'h3FF, 32'hCAFE_F00D, 10'h000);
    @(posedge clock);
    #1;
    reset = 1'b0;
    waitIdle("replay", 5000);
    checkOutput("replay_commit", 64'(commit_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
